ahb_slave_mux: RTL and testbench

AHB-Lite response multiplexor with an integrated default slave, placed directly downstream of the address decoder. It takes the decoder's one-hot `HSEL` during the address phase and registers the selection for the data phase. During the data phase it routes the selected slave's `HRDATA`/`HREADYOUT`/`HRESP` back to the master. Transfers to unmapped addresses receive the AHB two-cycle ERROR response from the default slave.

---
 rtl/ahb_pkg.sv | 19 +
 rtl/ahb_default_slave.sv | 42 ++++
 rtl/ahb_slave_mux.sv | 77 +++++++
 tb/tb_ahb_slave_mux.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type used by the
// slave response multiplexor.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } def_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers every unmapped active transfer with the two-cycle
// AHB ERROR response (wait+ERROR, then ready+ERROR).
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic HCLK,
    input  logic HRESET,
    input  logic def_sampled_i,
    output logic hreadyout_o,
    output logic hresp_o
);

    def_state_e state_q, state_d;

    always_ff @(posedge HCLK) begin
        if (HRESET) state_q <= DS_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        hreadyout_o = 1'b1;
        hresp_o     = RESP_OKAY;
        case (state_q)
            DS_IDLE: begin
                if (def_sampled_i) state_d = DS_ERR1;
            end
            DS_ERR1: begin
                hreadyout_o = 1'b0;
                hresp_o     = RESP_ERROR;
                state_d     = DS_ERR2;
            end
            DS_ERR2: begin
                hresp_o = RESP_ERROR;
                // A fresh unmapped address phase here chains straight into ERR1.
                state_d = def_sampled_i ? DS_ERR1 : DS_IDLE;
            end
            default: state_d = DS_IDLE;
        endcase
    end

endmodule

// File: rtl/ahb_slave_mux.sv
// AHB-Lite response multiplexor: registers the decoder select for the data
// phase and routes the selected slave (or the default slave) back to the master.
module ahb_slave_mux
    import ahb_pkg::*;
#(
    parameter int NSLV = 4,
    parameter int DW   = 32
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [NSLV-1:0]    HSEL,
    input  logic [1:0]         HTRANS,
    input  logic [NSLV*DW-1:0] HRDATA_S,
    input  logic [NSLV-1:0]    HREADYOUT_S,
    input  logic [NSLV-1:0]    HRESP_S,
    output logic [DW-1:0]      HRDATA,
    output logic               HREADY,
    output logic               HRESP
);

    // sel_q[NSLV] is the default slave; all-zero means no data phase (NONE).
    logic [NSLV:0]   sel_q, sel_d;
    logic [NSLV-1:0] hsel_low;
    logic            trans_active;
    logic            def_sampled;
    logic            def_hready, def_hresp;

    assign trans_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    // Isolate the lowest set bit so a multi-hot select resolves deterministically.
    assign hsel_low     = HSEL & (~HSEL + {{(NSLV-1){1'b0}}, 1'b1});
    assign def_sampled  = HREADY && (HSEL == '0) && trans_active;

    always_comb begin
        sel_d = sel_q;
        if (HREADY) begin
            if (HSEL != '0) begin
                sel_d = {1'b0, hsel_low};
            end else if (trans_active) begin
                sel_d       = '0;
                sel_d[NSLV] = 1'b1;
            end else begin
                sel_d = '0;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) sel_q <= '0;
        else        sel_q <= sel_d;
    end

    ahb_default_slave u_def (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .def_sampled_i (def_sampled),
        .hreadyout_o   (def_hready),
        .hresp_o       (def_hresp)
    );

    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = RESP_OKAY;
        for (int k = 0; k < NSLV; k++) begin
            if (sel_q[k]) begin
                HRDATA = HRDATA_S[k*DW +: DW];
                HREADY = HREADYOUT_S[k];
                HRESP  = HRESP_S[k];
            end
        end
        if (sel_q[NSLV]) begin
            HREADY = def_hready;
            HRESP  = def_hresp;
        end
    end

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Bench for ahb_slave_mux: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_ahb_slave_mux;
    localparam int NSLV = 4;
    localparam int DW   = 32;

    logic               HCLK = 1'b0;
    logic               HRESET;
    logic [NSLV-1:0]    HSEL;
    logic [1:0]         HTRANS;
    logic [NSLV*DW-1:0] HRDATA_S;
    logic [NSLV-1:0]    HREADYOUT_S;
    logic [NSLV-1:0]    HRESP_S;
    logic [DW-1:0]      HRDATA;
    logic               HREADY;
    logic               HRESP;

    ahb_slave_mux #(.NSLV(NSLV), .DW(DW)) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HSEL        (HSEL),
        .HTRANS      (HTRANS),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP)
    );

    always #5 HCLK = ~HCLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: which data phase is live (-1 none, NSLV default slave) and how far
    // into the two-cycle error response we are (0 none, 1 first, 2 second).
    int          m_sel   = -1;
    int          m_err   = 0;
    bit          m_valid = 1'b0;
    logic        e_rdy, e_rsp;
    logic [DW-1:0] e_dat;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_eval();
        if (m_sel < 0) begin
            e_rdy = 1'b1; e_rsp = 1'b0; e_dat = '0;
        end else if (m_sel == NSLV) begin
            e_rdy = (m_err != 1);
            e_rsp = (m_err != 0);
            e_dat = '0;
        end else begin
            e_rdy = HREADYOUT_S[m_sel];
            e_rsp = HRESP_S[m_sel];
            e_dat = HRDATA_S[m_sel*DW +: DW];
        end
    endtask

    task automatic model_update();
        bit active, unmapped, found;
        active   = HTRANS[1];
        unmapped = (HSEL == '0) && active;
        if (HRESET) begin
            m_sel = -1; m_err = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_err == 1)      m_err = 2;
            else                 m_err = (e_rdy && unmapped) ? 1 : 0;
            if (e_rdy) begin
                found = 1'b0;
                for (int k = 0; k < NSLV; k++)
                    if (!found && HSEL[k]) begin m_sel = k; found = 1'b1; end
                if (!found) m_sel = active ? NSLV : -1;
            end
        end
    endtask

    // One bus cycle: check outputs mid-cycle, advance the model on the edge,
    // then hand control back just after the edge for new inputs.
    task automatic run_cycle(input bit lit, input logic lr, input logic lp, input logic [DW-1:0] ld);
        @(negedge HCLK);
        if (m_valid) begin
            model_eval();
            chk("model_hready", {31'b0, HREADY}, {31'b0, e_rdy});
            chk("model_hresp",  {31'b0, HRESP},  {31'b0, e_rsp});
            chk("model_hrdata", HRDATA, e_dat);
        end
        if (lit) begin
            chk("lit_hready", {31'b0, HREADY}, {31'b0, lr});
            chk("lit_hresp",  {31'b0, HRESP},  {31'b0, lp});
            chk("lit_hrdata", HRDATA, ld);
        end
        @(posedge HCLK);
        model_update();
        #1;
    endtask

    task automatic set_in(input logic [NSLV-1:0] s, input logic [1:0] t);
        HSEL = s; HTRANS = t;
    endtask

    initial begin
        HRESET = 1'b1;
        set_in(4'b0100, 2'b10);
        HREADYOUT_S = '1;
        HRESP_S     = '0;
        for (int k = 0; k < NSLV; k++) HRDATA_S[k*DW +: DW] = 32'hA0A0_0000 + k;

        // Reset held for two edges with an active select on the bus.
        run_cycle(0, 1'b0, 1'b0, '0);
        run_cycle(1, 1'b1, 1'b0, '0);
        HRESET = 1'b0;
        set_in(4'b0000, 2'b00);
        run_cycle(1, 1'b1, 1'b0, '0);

        // Zero-wait read from slave 1.
        HRDATA_S[1*DW +: DW] = 32'hDEAD_BEEF;
        set_in(4'b0010, 2'b10);
        run_cycle(1, 1'b1, 1'b0, '0);
        set_in(4'b0000, 2'b00);
        run_cycle(1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        HRDATA_S[1*DW +: DW] = 32'hA0A0_0001;

        // Slave 3 stalls three cycles while the next address phase targets slave 0.
        set_in(4'b1000, 2'b10);
        run_cycle(1, 1'b1, 1'b0, '0);
        set_in(4'b0001, 2'b10);
        HREADYOUT_S[3] = 1'b0;
        for (int i = 0; i < 3; i++) run_cycle(1, 1'b0, 1'b0, 32'hA0A0_0003);
        HREADYOUT_S[3] = 1'b1;
        run_cycle(1, 1'b1, 1'b0, 32'hA0A0_0003);

        // Unmapped NONSEQ: two-cycle ERROR, then an unmapped IDLE gets OKAY.
        set_in(4'b0000, 2'b10);
        run_cycle(1, 1'b1, 1'b0, 32'hA0A0_0000);
        set_in(4'b0000, 2'b00);
        run_cycle(1, 1'b0, 1'b1, '0);
        run_cycle(1, 1'b1, 1'b1, '0);
        run_cycle(1, 1'b1, 1'b0, '0);
        run_cycle(1, 1'b1, 1'b0, '0);

        // Back-to-back unmapped accesses: ERR2 chains directly into ERR1.
        set_in(4'b0000, 2'b10);
        run_cycle(1, 1'b1, 1'b0, '0);
        run_cycle(1, 1'b0, 1'b1, '0);
        run_cycle(1, 1'b1, 1'b1, '0);
        set_in(4'b0000, 2'b00);
        run_cycle(1, 1'b0, 1'b1, '0);
        run_cycle(1, 1'b1, 1'b1, '0);
        run_cycle(1, 1'b1, 1'b0, '0);

        // Multi-hot select resolves to the lowest index.
        set_in(4'b1010, 2'b11);
        run_cycle(1, 1'b1, 1'b0, '0);
        set_in(4'b0000, 2'b10);
        run_cycle(1, 1'b1, 1'b0, 32'hA0A0_0001);

        // Reset during ERR1 abandons the error response.
        set_in(4'b0000, 2'b00);
        HRESET = 1'b1;
        run_cycle(1, 1'b0, 1'b1, '0);
        HRESET = 1'b0;
        run_cycle(1, 1'b1, 1'b0, '0);

        // Randomized traffic, model-checked every cycle.
        for (int i = 0; i < 3000; i++) begin
            int r;
            HRESET = ($urandom_range(0, 59) == 0);
            r = $urandom_range(0, 9);
            if (r < 6)      HSEL = 4'b0001 << $urandom_range(0, NSLV - 1);
            else if (r < 8) HSEL = '0;
            else            HSEL = 4'($urandom);
            HTRANS = 2'($urandom);
            for (int k = 0; k < NSLV; k++) begin
                HRDATA_S[k*DW +: DW] = $urandom;
                HREADYOUT_S[k]       = ($urandom_range(0, 3) != 0);
            end
            HRESP_S = 4'($urandom);
            run_cycle(0, 1'b0, 1'b0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
